memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
// - Shares one single-port unified SRAM (1-cycle read latency) between the fetch-stage
//   instruction read port and the memory-stage data read/write port.
// - Sits between stage1_fetch / stage4_memory and the memory macro. Owns grant selection,
//   starvation prevention, per-requester 1-entry response buffering and fetch flush on branch.
// PARAMETERS
// - ADDR_WIDTH      32  byte-address width of both requester ports
// - DATA_WIDTH      32  word width; byte enables are DATA_WIDTH/8 bits
// - MEM_ADDR_WIDTH  14  word-address width of the SRAM port
// - STARVE_LIMIT     4  max consecutive data grants while fetch waits; range 1..15
// PORTS
// - clk           in   1    clock
// - rst           in   1    asynchronous reset, active-high
// - i_req_valid   in   1    fetch read request
// - i_req_ready   out  1    fetch request accepted this cycle when valid&ready
// - i_req_addr    in   ADDR_WIDTH  fetch byte address
// - i_rsp_valid   out  1    fetch read data valid
// - i_rsp_ready   in   1    fetch consumer accepts response
// - i_rsp_data    out  DATA_WIDTH  fetch read data
// - i_flush       in   1    branch taken; discard in-flight or buffered fetch response
// - d_req_valid   in   1    data request
// - d_req_ready   out  1    data request accepted this cycle when valid&ready
// - d_req_write   in   1    1 = write, 0 = read
// - d_req_addr    in   ADDR_WIDTH  data byte address
// - d_req_wdata   in   DATA_WIDTH  write data
// - d_req_be      in   DATA_WIDTH/8  write byte enables
// - d_rsp_valid   out  1    data read data valid; writes produce no response
// - d_rsp_ready   in   1    data consumer accepts response
// - d_rsp_data    out  DATA_WIDTH  data read data
// - mem_en, mem_we  out 1   SRAM enable / write enable
// - mem_addr      out  MEM_ADDR_WIDTH  word address = req_addr[MEM_ADDR_WIDTH+1:2]; addr[1:0] ignored
// - mem_wdata     out  DATA_WIDTH;  mem_be  out  DATA_WIDTH/8;  mem_rdata  in  DATA_WIDTH
// BEHAVIOUR
// - Reset: all *_ready, *_rsp_valid, mem_en, mem_we = 0; rsp_data = 0; starve counter = 0;
//   buffers empty; in-flight tag = none.
// - Eligibility: read requester X eligible iff its buffer is empty, or it is being drained
//   this cycle (rsp_valid & rsp_ready). Data writes are always eligible.
// - Grant is combinational; at most one grant per cycle. Only the granted requester sees
//   ready = 1. mem_* is driven from the winner in the same cycle; mem_en = 0 when there is no grant.
// - Default policy: data wins a conflict unless starve_cnt == STARVE_LIMIT, then fetch wins.
//   starve_cnt increments on each data grant while i_req_valid is high. It clears on any
//   fetch grant, or when i_req_valid is low. It saturates at STARVE_LIMIT.
// - Read latency: accepted in cycle N; mem_rdata is captured into the issuer's buffer at the
//   edge ending N+1; rsp_valid is high from N+2 until handshake. Back-to-back reads from one
//   requester with rsp_ready held high give 1 response/cycle.
// - Buffer: 1 entry per requester. rsp_valid = buffer full; rsp_data = buffer contents, held
//   stable while rsp_ready = 0.
// - Registered in-flight tag {valid, owner} is recorded at grant, for reads only.
// - Flush: i_flush clears a full fetch buffer and kills an in-flight fetch tag in the same
//   cycle, so no response appears for it. A fetch request accepted in the flush cycle itself
//   is NOT killed. Data traffic is unaffected.
// - Simultaneous capture into a buffer and drain of that buffer: capture wins; buffer stays full.
// - Reset mid-transaction drops all in-flight and buffered responses; the SRAM write of the
//   current cycle is not guaranteed.
// CONFIGURATION
// - ARB_ROUND_ROBIN_EN defined: on conflict, the requester not granted last wins
//   (last-grant flop, reset = fetch, so data wins the first conflict). starve_cnt logic is
//   removed and STARVE_LIMIT is ignored.
// - Not defined: data-priority with the starvation limit described above.
// TESTING
// - Fetch read 0x100 alone, mem word[0x40]=0xDEADBEEF -> i_req_ready same cycle; i_rsp_valid=1,
//   data 0xDEADBEEF two cycles later.
// - Data write 0x200 data 0x12345678 be 4'b0011, then read 0x200 ->
//   d_rsp_data = 0x00005678 (prior word 0), no response for the write.
// - Both valid every cycle, STARVE_LIMIT=4 -> grant pattern D,D,D,D,F repeating; with
//   ARB_ROUND_ROBIN_EN -> D,F,D,F.
// - d_rsp_ready=0 after data read -> d_req_ready=0 for next data read; data write still accepted;
//   d_rsp_data stable until ready.
// - Fetch read accepted cycle N, i_flush at N+1 -> no i_rsp_valid; fetch read accepted at N+1
//   returns normally at N+3.
// - Assert rst with buffers full and a read in flight -> all rsp_valid=0 immediately; after release
//   no stale response appears.

Source files
------------

// File: rtl/memory_arbiter.sv
//------------------------------------------------------------------------------
// memory_arbiter
//
// Shares one single-port SRAM (registered read, 1-cycle latency) between the
// fetch-stage instruction read port (i_*) and the memory-stage data read/write
// port (d_*). Handles grant selection, starvation prevention, a one-entry
// response buffer per requester and discarding of fetch responses on a branch
// flush.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined     : conflicts go to the requester that did not win last time
//                 (last-grant flop resets to "fetch", so data wins the first
//                 conflict); the starvation counter is not built.
//   not defined : data wins conflicts, except that fetch wins once data has
//                 been granted STARVE_LIMIT times in a row while fetch waited.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   i_req_valid/ready/addr   fetch read request (byte address)
//   i_rsp_valid/ready/data   fetch read response
//   i_flush                  branch taken: drop buffered/in-flight fetch data
//   d_req_valid/ready        data request handshake
//   d_req_write/addr/wdata/be data request payload (write when d_req_write)
//   d_rsp_valid/ready/data   data read response (writes give no response)
//   mem_en, mem_we           SRAM enable / write enable
//   mem_addr                 SRAM word address (byte address bits [MAW+1:2])
//   mem_wdata, mem_be        SRAM write data / byte enables
//   mem_rdata                SRAM read data, valid the cycle after a read
//------------------------------------------------------------------------------
module memory_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int MEM_ADDR_WIDTH = 14,
   parameter int STARVE_LIMIT   = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   // fetch port
   input  logic                      i_req_valid,
   output logic                      i_req_ready,
   input  logic [ADDR_WIDTH-1:0]     i_req_addr,
   output logic                      i_rsp_valid,
   input  logic                      i_rsp_ready,
   output logic [DATA_WIDTH-1:0]     i_rsp_data,
   input  logic                      i_flush,
   // data port
   input  logic                      d_req_valid,
   output logic                      d_req_ready,
   input  logic                      d_req_write,
   input  logic [ADDR_WIDTH-1:0]     d_req_addr,
   input  logic [DATA_WIDTH-1:0]     d_req_wdata,
   input  logic [DATA_WIDTH/8-1:0]   d_req_be,
   output logic                      d_rsp_valid,
   input  logic                      d_rsp_ready,
   output logic [DATA_WIDTH-1:0]     d_rsp_data,
   // SRAM port
   output logic                      mem_en,
   output logic                      mem_we,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   output logic [DATA_WIDTH/8-1:0]   mem_be,
   input  logic [DATA_WIDTH-1:0]     mem_rdata
);

   // Requester indices for the per-requester buffer arrays.
   localparam int NUM_REQ   = 2;
   localparam int REQ_FETCH = 0;
   localparam int REQ_DATA  = 1;

   //---------------------------------------------------------------------------
   // State
   //---------------------------------------------------------------------------
   logic [NUM_REQ-1:0]    buf_full_reg;
   logic [NUM_REQ-1:0]    buf_full_next;
   logic [DATA_WIDTH-1:0] buf_data_reg  [NUM_REQ];
   logic [DATA_WIDTH-1:0] buf_data_next [NUM_REQ];

   // Outstanding SRAM read: owner 0 = fetch, 1 = data.
   logic tag_valid_reg, tag_valid_next;
   logic tag_owner_reg, tag_owner_next;

   //---------------------------------------------------------------------------
   // Per-requester views of the response handshake
   //---------------------------------------------------------------------------
   logic [NUM_REQ-1:0] rsp_ready_vec;
   logic [NUM_REQ-1:0] flush_vec;
   logic [NUM_REQ-1:0] drain_vec;
   logic [NUM_REQ-1:0] capture_vec;

   assign rsp_ready_vec = {d_rsp_ready, i_rsp_ready};
   // Only the fetch side is ever flushed.
   assign flush_vec     = {1'b0, i_flush};

   //---------------------------------------------------------------------------
   // Eligibility and grant
   //---------------------------------------------------------------------------
   logic fetch_eligible;
   logic data_eligible;
   logic fetch_priority;
   logic grant_fetch;
   logic grant_data;

   // A read may issue only if its buffer will have room; a buffer that is
   // handing its entry over this cycle counts as having room. Writes never
   // produce a response so they are always eligible.
   assign fetch_eligible = i_req_valid &
                           (~buf_full_reg[REQ_FETCH] | rsp_ready_vec[REQ_FETCH]);
   assign data_eligible  = d_req_valid &
                           (d_req_write | ~buf_full_reg[REQ_DATA] | rsp_ready_vec[REQ_DATA]);

   always_comb begin
      grant_fetch = 1'b0;
      grant_data  = 1'b0;
      // Grants are suppressed while reset is held so the SRAM is left idle.
      if (!rst) begin
         if (fetch_eligible && (!data_eligible || fetch_priority)) begin
            grant_fetch = 1'b1;
         end else if (data_eligible) begin
            grant_data = 1'b1;
         end
      end
   end

   assign i_req_ready = grant_fetch;
   assign d_req_ready = grant_data;

   //---------------------------------------------------------------------------
   // Conflict policy
   //---------------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
   logic last_grant_data_reg;
   logic last_grant_data_next;

   // The starvation limit has no meaning under round robin.
   localparam logic [3:0] UNUSED_STARVE_LIMIT = 4'(STARVE_LIMIT);

   assign fetch_priority = last_grant_data_reg;

   always_comb begin
      last_grant_data_next = last_grant_data_reg;
      if (grant_data) begin
         last_grant_data_next = 1'b1;
      end else if (grant_fetch) begin
         last_grant_data_next = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_data_reg <= 1'b0;
      end else begin
         last_grant_data_reg <= last_grant_data_next;
      end
   end
`else
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   logic [3:0] starve_cnt_reg;
   logic [3:0] starve_cnt_next;

   // Fetch takes over once data has won STARVE_MAX consecutive grants while
   // fetch was asking.
   assign fetch_priority = (starve_cnt_reg == STARVE_MAX);

   always_comb begin
      starve_cnt_next = starve_cnt_reg;
      if (!i_req_valid || grant_fetch) begin
         starve_cnt_next = 4'd0;
      end else if (grant_data && (starve_cnt_reg != STARVE_MAX)) begin
         starve_cnt_next = starve_cnt_reg + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt_reg <= 4'd0;
      end else begin
         starve_cnt_reg <= starve_cnt_next;
      end
   end
`endif

   //---------------------------------------------------------------------------
   // SRAM drive: straight from the winner in the grant cycle
   //---------------------------------------------------------------------------
   assign mem_en    = grant_fetch | grant_data;
   assign mem_we    = grant_data & d_req_write;
   assign mem_addr  = grant_data ? d_req_addr[MEM_ADDR_WIDTH+1:2]
                                 : i_req_addr[MEM_ADDR_WIDTH+1:2];
   assign mem_wdata = d_req_wdata;
   assign mem_be    = mem_we ? d_req_be : '0;

   // Byte offset and bits above the SRAM range do not select anything.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{i_req_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2], i_req_addr[1:0],
                               d_req_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2], d_req_addr[1:0]};

   //---------------------------------------------------------------------------
   // In-flight tag: recorded for reads only
   //---------------------------------------------------------------------------
   assign tag_valid_next = grant_fetch | (grant_data & ~d_req_write);
   assign tag_owner_next = grant_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_valid_reg <= 1'b0;
         tag_owner_reg <= 1'b0;
      end else begin
         tag_valid_reg <= tag_valid_next;
         tag_owner_reg <= tag_owner_next;
      end
   end

   //---------------------------------------------------------------------------
   // Response buffers, one entry per requester
   //---------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp_buf
         assign drain_vec[gi]   = buf_full_reg[gi] & rsp_ready_vec[gi];
         // A flush kills the returning fetch read in the same cycle, so it is
         // never captured. A fetch issued during the flush cycle is only in
         // tag_*_next, and therefore survives.
         assign capture_vec[gi] = tag_valid_reg & (tag_owner_reg == 1'(gi)) & ~flush_vec[gi];

         // Capture beats drain: when both happen the buffer stays full with
         // the new word.
         assign buf_full_next[gi] = capture_vec[gi] |
                                    (buf_full_reg[gi] & ~drain_vec[gi] & ~flush_vec[gi]);
         assign buf_data_next[gi] = capture_vec[gi] ? mem_rdata : buf_data_reg[gi];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               buf_full_reg[gi] <= 1'b0;
               buf_data_reg[gi] <= '0;
            end else begin
               buf_full_reg[gi] <= buf_full_next[gi];
               buf_data_reg[gi] <= buf_data_next[gi];
            end
         end
      end
   endgenerate

   assign i_rsp_valid = buf_full_reg[REQ_FETCH];
   assign i_rsp_data  = buf_data_reg[REQ_FETCH];
   assign d_rsp_valid = buf_full_reg[REQ_DATA];
   assign d_rsp_data  = buf_data_reg[REQ_DATA];

endmodule

// File: tb/tb_memory_arbiter.sv
//------------------------------------------------------------------------------
// tb_memory_arbiter
//
// Directed scenarios followed by a randomized run, all compared cycle by cycle
// against a transaction-level reference: eligibility and priority are decided
// from the arbitration rules, each accepted read is queued with the word the
// reference memory holds at acceptance, and it lands in the requester's
// response slot one cycle later unless a flush discards it.
//------------------------------------------------------------------------------
module tb_memory_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MAW = 14;
   localparam int SL = 4;
   localparam int DEPTH = 1 << MAW;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           i_req_valid, i_req_ready, i_rsp_valid, i_rsp_ready, i_flush;
   logic [AW-1:0]  i_req_addr;
   logic [DW-1:0]  i_rsp_data;
   logic           d_req_valid, d_req_ready, d_req_write, d_rsp_valid, d_rsp_ready;
   logic [AW-1:0]  d_req_addr;
   logic [DW-1:0]  d_req_wdata, d_rsp_data;
   logic [3:0]     d_req_be;
   logic           mem_en, mem_we;
   logic [MAW-1:0] mem_addr;
   logic [DW-1:0]  mem_wdata, mem_rdata;
   logic [3:0]     mem_be;

   always #5 clk = ~clk;

   memory_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_ADDR_WIDTH(MAW), .STARVE_LIMIT(SL)
   ) dut (
      .clk(clk), .rst(rst),
      .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
      .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data),
      .i_flush(i_flush),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_write(d_req_write),
      .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_be(d_req_be),
      .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
   );

   // SRAM macro model: registered read, byte-enabled write.
   logic [DW-1:0] sram [0:DEPTH-1];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
         end else begin
            mem_rdata <= sram[mem_addr];
         end
      end
   end

   // Reference state.
   typedef struct { int owner; logic [DW-1:0] data; } pend_t;
   logic [DW-1:0] model_mem [0:DEPTH-1];
   pend_t         pend_q[$];
   bit            m_full [2];
   logic [DW-1:0] m_data [2];
   int            m_starve;
   int            m_last;
   int            last_win;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int word_of(input logic [AW-1:0] a);
      return int'(a[MAW+1:2]);
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      int w;
      w = $urandom_range(0, 65);
      if (w == 65) w = 128;
      return ($urandom & 32'hFFFF_0003) | (32'(w) << 2);
   endfunction

   task automatic model_reset();
      pend_q.delete();
      m_full[0] = 1'b0;
      m_full[1] = 1'b0;
      m_starve  = 0;
      m_last    = 0;
   endtask

   task automatic set_idle();
      i_req_valid = 1'b0; i_flush = 1'b0;
      d_req_valid = 1'b0; d_req_write = 1'b0;
      i_req_addr = '0; d_req_addr = '0; d_req_wdata = '0; d_req_be = '0;
   endtask

   // One clock: called just after a falling edge with inputs already applied.
   task automatic step();
      int    win;
      bit    i_ok, d_ok, f_first, drain0, drain1, cap0, cap1;
      pend_t p;
      int    w;
      #1;
      i_ok = i_req_valid && (!m_full[0] || i_rsp_ready);
      d_ok = d_req_valid && (d_req_write || !m_full[1] || d_rsp_ready);
`ifdef ARB_ROUND_ROBIN_EN
      f_first = (m_last == 1);
`else
      f_first = (m_starve == SL);
`endif
      if (i_ok && d_ok) win = f_first ? 0 : 1;
      else if (i_ok)    win = 0;
      else if (d_ok)    win = 1;
      else              win = -1;
      last_win = win;

      check("i_req_ready", 32'(i_req_ready), 32'(win == 0));
      check("d_req_ready", 32'(d_req_ready), 32'(win == 1));
      check("mem_en", 32'(mem_en), 32'(win != -1));
      if (win == 0) begin
         check("mem_addr_i", 32'(mem_addr), 32'(word_of(i_req_addr)));
         check("mem_we_i", 32'(mem_we), 32'd0);
      end
      if (win == 1) begin
         check("mem_addr_d", 32'(mem_addr), 32'(word_of(d_req_addr)));
         check("mem_we_d", 32'(mem_we), 32'(d_req_write));
         if (d_req_write) begin
            check("mem_be", 32'(mem_be), 32'(d_req_be));
            check("mem_wdata", mem_wdata, d_req_wdata);
         end
      end
      check("i_rsp_valid", 32'(i_rsp_valid), 32'(m_full[0]));
      if (m_full[0]) check("i_rsp_data", i_rsp_data, m_data[0]);
      check("d_rsp_valid", 32'(d_rsp_valid), 32'(m_full[1]));
      if (m_full[1]) check("d_rsp_data", d_rsp_data, m_data[1]);

      // Advance the reference to the state after this clock edge.
      drain0 = m_full[0] && i_rsp_ready;
      drain1 = m_full[1] && d_rsp_ready;
      cap0 = 1'b0;
      cap1 = 1'b0;
      if (pend_q.size() != 0) begin
         p = pend_q.pop_front();
         if (p.owner == 1) begin
            cap1 = 1'b1; m_data[1] = p.data;
         end else if (!i_flush) begin
            cap0 = 1'b1; m_data[0] = p.data;
         end
      end
      m_full[0] = cap0 || (m_full[0] && !drain0 && !i_flush);
      m_full[1] = cap1 || (m_full[1] && !drain1);
      if (win == 0) begin
         p.owner = 0; p.data = model_mem[word_of(i_req_addr)];
         pend_q.push_back(p);
      end else if (win == 1) begin
         w = word_of(d_req_addr);
         if (d_req_write) begin
            for (int b = 0; b < 4; b++)
               if (d_req_be[b]) model_mem[w][b*8 +: 8] = d_req_wdata[b*8 +: 8];
         end else begin
            p.owner = 1; p.data = model_mem[w];
            pend_q.push_back(p);
         end
      end
      if (!i_req_valid || win == 0) m_starve = 0;
      else if (win == 1 && m_starve < SL) m_starve++;
      if (win != -1) m_last = win;

      @(posedge clk);
      @(negedge clk);
   endtask

   logic [DW-1:0] held;
   int            prev_win;

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         logic [DW-1:0] v;
         v = (i < 64) ? DW'($urandom) : '0;
         if (i == 64) v = 32'hDEADBEEF;
         sram[i] <= v;
         model_mem[i] = v;
      end
      model_reset();

      // Reset holds everything quiet even with requests asserted.
      i_req_valid = 1'b1; i_req_addr = 32'h100; i_rsp_ready = 1'b1; i_flush = 1'b0;
      d_req_valid = 1'b1; d_req_write = 1'b1; d_req_addr = 32'h200;
      d_req_wdata = 32'hFFFF_FFFF; d_req_be = 4'hF; d_rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_i_req_ready", 32'(i_req_ready), 32'd0);
      check("rst_d_req_ready", 32'(d_req_ready), 32'd0);
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_i_rsp_valid", 32'(i_rsp_valid), 32'd0);
      check("rst_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
      check("rst_i_rsp_data", i_rsp_data, 32'd0);
      check("rst_d_rsp_data", d_rsp_data, 32'd0);
      @(negedge clk);
      set_idle();
      rst = 1'b0;
      model_reset();
      step();

      // Lone fetch of 0x100 returns word 0x40 two cycles later.
      i_req_valid = 1'b1; i_req_addr = 32'h100;
      step();
      set_idle();
      step();
      check("fetch_rsp_valid", 32'(i_rsp_valid), 32'd1);
      check("fetch_rsp_data", i_rsp_data, 32'hDEADBEEF);
      step();

      // Partial write then read-back of 0x200.
      d_req_valid = 1'b1; d_req_write = 1'b1; d_req_addr = 32'h200;
      d_req_wdata = 32'h12345678; d_req_be = 4'b0011;
      step();
      d_req_write = 1'b0; d_req_be = 4'b0000; d_req_wdata = '0;
      step();
      set_idle();
      check("write_no_rsp", 32'(d_rsp_valid), 32'd0);
      step();
      check("rmw_rsp_valid", 32'(d_rsp_valid), 32'd1);
      check("rmw_rsp_data", d_rsp_data, 32'h00005678);
      step();

      // Both ports asking every cycle.
      prev_win = -1;
      for (int k = 0; k < 10; k++) begin
         i_req_valid = 1'b1; i_req_addr = rand_addr();
         d_req_valid = 1'b1; d_req_write = 1'b0; d_req_addr = rand_addr();
         step();
`ifdef ARB_ROUND_ROBIN_EN
         if (k > 0) check("rr_alternate", 32'(last_win), 32'(1 - prev_win));
`else
         check("starve_pattern", 32'(last_win), (k % 5 == 4) ? 32'd0 : 32'd1);
`endif
         prev_win = last_win;
      end
      set_idle();
      step();
      step();

      // Unread data response blocks further data reads but not writes.
      d_rsp_ready = 1'b0;
      d_req_valid = 1'b1; d_req_write = 1'b0; d_req_addr = 32'h0000_0014;
      step();
      set_idle();
      step();
      held = d_rsp_data;
      check("bp_rsp_valid", 32'(d_rsp_valid), 32'd1);
      check("bp_rsp_value", held, model_mem[5]);
      d_req_valid = 1'b1; d_req_write = 1'b0; d_req_addr = 32'h0000_0020;
      #1;
      check("bp_read_blocked", 32'(d_req_ready), 32'd0);
      step();
      d_req_write = 1'b1; d_req_wdata = 32'hA5A5_5A5A; d_req_be = 4'b1111;
      d_req_addr = 32'h0000_0030;
      #1;
      check("bp_write_ok", 32'(d_req_ready), 32'd1);
      step();
      set_idle();
      check("bp_rsp_stable", d_rsp_data, held);
      d_rsp_ready = 1'b1;
      step();
      step();

      // Flush kills the older fetch but not one accepted in the flush cycle.
      i_req_valid = 1'b1; i_req_addr = 32'h0000_0008;
      step();
      i_flush = 1'b1; i_req_addr = 32'h100;
      step();
      set_idle();
      check("flush_killed", 32'(i_rsp_valid), 32'd0);
      step();
      check("flush_next_valid", 32'(i_rsp_valid), 32'd1);
      check("flush_next_data", i_rsp_data, 32'hDEADBEEF);
      step();
      step();

      // Reset with both buffers full and a read outstanding.
      i_rsp_ready = 1'b0; d_rsp_ready = 1'b0;
      i_req_valid = 1'b1; i_req_addr = 32'h0000_0004;
      step();
      set_idle();
      d_req_valid = 1'b1; d_req_addr = 32'h0000_000C;
      step();
      d_req_addr = 32'h0000_0010;
      step();
      set_idle();
      check("pre_rst_i_full", 32'(i_rsp_valid), 32'd1);
      check("pre_rst_d_full", 32'(d_rsp_valid), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_i_valid", 32'(i_rsp_valid), 32'd0);
      check("mid_rst_d_valid", 32'(d_rsp_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      i_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) step();

      // Randomized traffic.
      for (int k = 0; k < 600; k++) begin
         i_req_valid = ($urandom_range(0, 9) < 6);
         i_req_addr  = rand_addr();
         i_rsp_ready = ($urandom_range(0, 9) < 7);
         i_flush     = ($urandom_range(0, 9) == 0);
         d_req_valid = ($urandom_range(0, 9) < 6);
         d_req_write = ($urandom_range(0, 9) < 4);
         d_req_addr  = rand_addr();
         d_req_wdata = DW'($urandom);
         d_req_be    = 4'($urandom);
         d_rsp_ready = ($urandom_range(0, 9) < 7);
         step();
      end
      set_idle();
      i_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
      step();
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
